// File: rtl/ysyx_22040759_pc_gen.sv
// IF-stage next-PC generator: holds the fetch PC, presents it over valid/ready,
// and arbitrates trap > branch > buffered > sequential redirects without disturbing an open handshake.
module ysyx_22040759_pc_gen #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
    parameter int unsigned     INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] link_pc,
    output logic            redirect_pend,
    output logic            misalign
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hold_q, hold_d;
    logic            pend_vld_q, pend_vld_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            misalign_q, misalign_d;

    logic            fire;
    logic            redir;
    logic [XLEN-1:0] redir_tgt;
    logic            load;
    logic [XLEN-1:0] load_tgt;

    assign if_valid      = (state_q == RUN) && (!stall || hold_q);
    assign fire          = if_valid && if_ready;
    assign redir         = trap_valid || br_valid;
    assign redir_tgt     = trap_valid ? trap_target : br_target;
    assign if_pc         = pc_q;
    assign link_pc       = pc_q + STEP;
    assign redirect_pend = pend_vld_q;
    assign misalign      = misalign_q;

    always_comb begin
        state_d     = RUN;
        pc_d        = pc_q;
        hold_d      = if_valid && !if_ready;
        pend_vld_d  = pend_vld_q;
        pend_trap_d = pend_trap_q;
        pend_tgt_d  = pend_tgt_q;
        misalign_d  = 1'b0;
        load        = 1'b0;
        load_tgt    = '0;

        if (fire) begin
            if (redir) begin
                load     = 1'b1;
                load_tgt = redir_tgt;
            end else if (pend_vld_q) begin
                load     = 1'b1;
                load_tgt = pend_tgt_q;
            end else begin
                pc_d = pc_q + STEP;
            end
            pend_vld_d  = 1'b0;
            pend_trap_d = 1'b0;
        end else if (if_valid) begin
            // Request is on the bus: buffer instead of moving if_pc; a pending trap outranks later branches.
            if (trap_valid) begin
                pend_vld_d  = 1'b1;
                pend_trap_d = 1'b1;
                pend_tgt_d  = trap_target;
            end else if (br_valid && !(pend_vld_q && pend_trap_q)) begin
                pend_vld_d  = 1'b1;
                pend_trap_d = 1'b0;
                pend_tgt_d  = br_target;
            end
        end else if (redir) begin
            load     = 1'b1;
            load_tgt = redir_tgt;
        end

        if (load) begin
            pc_d       = load_tgt & ~ALIGN_MASK;
            misalign_d = |(load_tgt & ALIGN_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            hold_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            pend_vld_q  <= pend_vld_d;
            pend_trap_q <= pend_trap_d;
            pend_tgt_q  <= pend_tgt_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_pc_gen.sv
// Directed bench for ysyx_22040759_pc_gen; a second instance with INST_BYTES=2 shares the stimulus.
module tb_ysyx_22040759_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid, trap_valid, if_ready;
    logic [31:0] br_target, trap_target;
    logic        if_valid, redirect_pend, misalign;
    logic [31:0] if_pc, link_pc;
    logic        if_valid2, redirect_pend2, misalign2;
    logic [31:0] if_pc2, link_pc2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ysyx_22040759_pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .INST_BYTES(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .link_pc(link_pc),
        .redirect_pend(redirect_pend), .misalign(misalign)
    );

    ysyx_22040759_pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .INST_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .if_valid(if_valid2), .if_ready(if_ready), .if_pc(if_pc2), .link_pc(link_pc2),
        .redirect_pend(redirect_pend2), .misalign(misalign2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; br_valid = 0; trap_valid = 0; if_ready = 0;
        br_target = '0; trap_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_valid); else passed++;
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL reset_pc got %h exp 80000000", if_pc); else passed++;
        checks++; if (link_pc !== 32'h8000_0004) $display("FAIL reset_link got %h exp 80000004", link_pc); else passed++;
        checks++; if (redirect_pend !== 1'b0) $display("FAIL reset_pend got %b exp 0", redirect_pend); else passed++;
        checks++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b exp 0", misalign); else passed++;
    endtask

    task automatic test_sequential();
        rst = 0; if_ready = 1;
        #1;
        checks++; if (if_valid !== 1'b0) $display("FAIL boot_valid got %b exp 0", if_valid); else passed++;
        tick();
        checks++; if (if_valid !== 1'b1) $display("FAIL run_valid got %b exp 1", if_valid); else passed++;
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL seq_pc0 got %h exp 80000000", if_pc); else passed++;
        tick();
        checks++; if (if_pc !== 32'h8000_0004) $display("FAIL seq_pc1 got %h exp 80000004", if_pc); else passed++;
        checks++; if (link_pc !== 32'h8000_0008) $display("FAIL seq_link1 got %h exp 80000008", link_pc); else passed++;
        tick();
        checks++; if (if_pc !== 32'h8000_0008) $display("FAIL seq_pc2 got %h exp 80000008", if_pc); else passed++;
    endtask

    task automatic test_pending_branch();
        do_reset();
        if_ready = 0; br_valid = 1; br_target = 32'h8000_0100;
        tick();
        br_valid = 0;
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL hold_pc got %h exp 80000000", if_pc); else passed++;
        checks++; if (redirect_pend !== 1'b1) $display("FAIL hold_pend got %b exp 1", redirect_pend); else passed++;
        tick();
        tick();
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL hold_pc3 got %h exp 80000000", if_pc); else passed++;
        checks++; if (if_valid !== 1'b1) $display("FAIL hold_valid got %b exp 1", if_valid); else passed++;
        if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h8000_0100) $display("FAIL pend_apply_pc got %h exp 80000100", if_pc); else passed++;
        checks++; if (redirect_pend !== 1'b0) $display("FAIL pend_clear got %b exp 0", redirect_pend); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        if_ready = 0;
        br_valid = 1; br_target = 32'h8000_0200;
        tick();
        br_valid = 0; trap_valid = 1; trap_target = 32'h8000_1000;
        tick();
        trap_valid = 0; br_valid = 1; br_target = 32'h8000_0300;
        tick();
        br_valid = 0;
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL prio_hold_pc got %h exp 80000000", if_pc); else passed++;
        if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h8000_1000) $display("FAIL prio_trap_kept got %h exp 80001000", if_pc); else passed++;
        if_ready = 0;
        tick();
        trap_valid = 1; trap_target = 32'h8000_2000;
        br_valid = 1;   br_target = 32'h8000_0500;
        tick();
        trap_valid = 0; br_valid = 0;
        checks++; if (redirect_pend !== 1'b1) $display("FAIL prio_same_pend got %b exp 1", redirect_pend); else passed++;
        if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h8000_2000) $display("FAIL prio_same_cycle got %h exp 80002000", if_pc); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1; if_ready = 1;
        #1;
        checks++; if (if_valid !== 1'b0) $display("FAIL stall_valid got %b exp 0", if_valid); else passed++;
        br_valid = 1; br_target = 32'h8000_0400;
        tick();
        br_valid = 0;
        checks++; if (if_pc !== 32'h8000_0400) $display("FAIL stall_redirect got %h exp 80000400", if_pc); else passed++;
        checks++; if (redirect_pend !== 1'b0) $display("FAIL stall_nopend got %b exp 0", redirect_pend); else passed++;
        stall = 0; if_ready = 0;
        #1;
        checks++; if (if_valid !== 1'b1) $display("FAIL unstall_valid got %b exp 1", if_valid); else passed++;
        tick();
        stall = 1;
        #1;
        checks++; if (if_valid !== 1'b1) $display("FAIL sticky_valid got %b exp 1", if_valid); else passed++;
        tick();
        checks++; if (if_valid !== 1'b1) $display("FAIL sticky_valid2 got %b exp 1", if_valid); else passed++;
        checks++; if (if_pc !== 32'h8000_0400) $display("FAIL sticky_pc got %h exp 80000400", if_pc); else passed++;
        if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h8000_0404) $display("FAIL sticky_fire_pc got %h exp 80000404", if_pc); else passed++;
        checks++; if (if_valid !== 1'b0) $display("FAIL post_fire_stall got %b exp 0", if_valid); else passed++;
    endtask

    task automatic test_misalign();
        do_reset();
        stall = 1; if_ready = 0;
        br_valid = 1; br_target = 32'h8000_0102;
        tick();
        br_valid = 0;
        checks++; if (if_pc !== 32'h8000_0100) $display("FAIL mis4_pc got %h exp 80000100", if_pc); else passed++;
        checks++; if (misalign !== 1'b1) $display("FAIL mis4_pulse got %b exp 1", misalign); else passed++;
        checks++; if (if_pc2 !== 32'h8000_0102) $display("FAIL mis2_pc got %h exp 80000102", if_pc2); else passed++;
        checks++; if (misalign2 !== 1'b0) $display("FAIL mis2_flag got %b exp 0", misalign2); else passed++;
        checks++; if (link_pc2 !== 32'h8000_0104) $display("FAIL mis2_link got %h exp 80000104", link_pc2); else passed++;
        tick();
        checks++; if (misalign !== 1'b0) $display("FAIL mis4_oneshot got %b exp 0", misalign); else passed++;
        stall = 0; if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h8000_0104) $display("FAIL step4 got %h exp 80000104", if_pc); else passed++;
        checks++; if (if_pc2 !== 32'h8000_0104) $display("FAIL step2a got %h exp 80000104", if_pc2); else passed++;
        tick();
        checks++; if (if_pc2 !== 32'h8000_0106) $display("FAIL step2b got %h exp 80000106", if_pc2); else passed++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        stall = 1; if_ready = 0;
        br_valid = 1; br_target = 32'hFFFF_FFFC;
        tick();
        br_valid = 0;
        checks++; if (link_pc !== 32'h0000_0000) $display("FAIL wrap_link got %h exp 00000000", link_pc); else passed++;
        stall = 0; if_ready = 1;
        tick();
        checks++; if (if_pc !== 32'h0000_0000) $display("FAIL wrap_pc got %h exp 00000000", if_pc); else passed++;
        if_ready = 0;
        tick();
        br_valid = 1; br_target = 32'h8000_0700;
        tick();
        br_valid = 0;
        checks++; if (redirect_pend !== 1'b1) $display("FAIL midrst_pend_set got %b exp 1", redirect_pend); else passed++;
        rst = 1;
        tick();
        checks++; if (redirect_pend !== 1'b0) $display("FAIL midrst_pend got %b exp 0", redirect_pend); else passed++;
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL midrst_pc got %h exp 80000000", if_pc); else passed++;
        checks++; if (if_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", if_valid); else passed++;
        rst = 0;
        tick();
        checks++; if (if_pc !== 32'h8000_0000) $display("FAIL after_rst_pc got %h exp 80000000", if_pc); else passed++;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_pending_branch();
        test_priority();
        test_stall();
        test_misalign();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
